iob_eth_bd_arb: RTL and testbench

IOB_ETH_BD_ARB -- requirements
Module: iob_eth_bd_arb

---
 rtl/iob_eth_bd_arb.sv | 170 +++++++++++++++++
 tb/tb_iob_eth_bd_arb.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_bd_arb.sv
// rtl/iob_eth_bd_arb.sv - TX/RX DMA buffer-descriptor RAM arbiter with lock and lock timeout
// Optional feature macro: IOB_ETH_BD_ARB_RX_PRIO_EN (fixed RX-over-TX priority in IDLE)
module iob_eth_bd_arb #(
    parameter int BD_ADDR_W = 8,
    parameter int DATA_W    = 32,
    parameter int LOCK_MAX  = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cke_i,
    input  logic                 tx_req_i,
    input  logic                 rx_req_i,
    input  logic                 tx_lock_i,
    input  logic                 rx_lock_i,
    input  logic                 tx_wen_i,
    input  logic                 rx_wen_i,
    input  logic [BD_ADDR_W-1:0] tx_addr_i,
    input  logic [BD_ADDR_W-1:0] rx_addr_i,
    input  logic [DATA_W-1:0]    tx_wdata_i,
    input  logic [DATA_W-1:0]    rx_wdata_i,
    output logic                 tx_ack_o,
    output logic                 rx_ack_o,
    output logic                 tx_rvalid_o,
    output logic                 rx_rvalid_o,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 bd_en_o,
    output logic                 bd_wen_o,
    output logic [BD_ADDR_W-1:0] bd_addr_o,
    output logic [DATA_W-1:0]    bd_wdata_o,
    input  logic [DATA_W-1:0]    bd_rdata_i,
    output logic                 lock_err_o
);

    localparam int CNT_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_TX = 2'd1,
        OWN_RX = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_rx_q, last_rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tx_pend_q, rx_pend_q;
    logic             tx_ack, rx_ack;

    always_comb begin
        state_d   = state_q;
        last_rx_d = last_rx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        tx_ack    = 1'b0;
        rx_ack    = 1'b0;
        if (!rst_i && cke_i) begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
`ifdef IOB_ETH_BD_ARB_RX_PRIO_EN
                    if (rx_req_i)      rx_ack = 1'b1;
                    else if (tx_req_i) tx_ack = 1'b1;
`else
                    // last_rx_q high means RX was served last, so TX goes next
                    if (tx_req_i && rx_req_i) begin
                        if (last_rx_q) tx_ack = 1'b1;
                        else           rx_ack = 1'b1;
                    end else if (tx_req_i) begin
                        tx_ack = 1'b1;
                    end else if (rx_req_i) begin
                        rx_ack = 1'b1;
                    end
`endif
                    if (tx_ack) begin
                        last_rx_d = 1'b0;
                        if (tx_lock_i) state_d = OWN_TX;
                    end
                    if (rx_ack) begin
                        last_rx_d = 1'b1;
                        if (rx_lock_i) state_d = OWN_RX;
                    end
                end
                OWN_TX: begin
                    if (!tx_req_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        // timeout: release and hand the next round to RX
                        state_d   = IDLE;
                        cnt_d     = '0;
                        err_d     = 1'b1;
                        last_rx_d = 1'b0;
                    end else begin
                        tx_ack = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (!tx_lock_i) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                OWN_RX: begin
                    if (!rx_req_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        err_d     = 1'b1;
                        last_rx_d = 1'b1;
                    end else begin
                        rx_ack = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (!rx_lock_i) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_rx_q <= 1'b1;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            tx_pend_q <= 1'b0;
            rx_pend_q <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            last_rx_q <= last_rx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            tx_pend_q <= tx_ack & ~tx_wen_i;
            rx_pend_q <= rx_ack & ~rx_wen_i;
        end
    end

    always_comb begin
        bd_wen_o   = 1'b0;
        bd_addr_o  = '0;
        bd_wdata_o = '0;
        if (tx_ack) begin
            bd_wen_o   = tx_wen_i;
            bd_addr_o  = tx_addr_i;
            bd_wdata_o = tx_wdata_i;
        end else if (rx_ack) begin
            bd_wen_o   = rx_wen_i;
            bd_addr_o  = rx_addr_i;
            bd_wdata_o = rx_wdata_i;
        end
    end

    assign tx_ack_o    = tx_ack;
    assign rx_ack_o    = rx_ack;
    assign bd_en_o     = tx_ack | rx_ack;
    assign tx_rvalid_o = tx_pend_q & ~rst_i;
    assign rx_rvalid_o = rx_pend_q & ~rst_i;
    assign rdata_o     = bd_rdata_i;
    assign lock_err_o  = err_q & ~rst_i;

endmodule

// File: tb/tb_iob_eth_bd_arb.sv
// tb/tb_iob_eth_bd_arb.sv - self-checking bench for iob_eth_bd_arb with a cycle-level reference model
module tb_iob_eth_bd_arb;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LM = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cke;
    logic          tx_req, rx_req, tx_lock, rx_lock, tx_wen, rx_wen;
    logic [AW-1:0] tx_addr, rx_addr;
    logic [DW-1:0] tx_wdata, rx_wdata;
    logic          tx_ack, rx_ack, tx_rvalid, rx_rvalid, bd_en, bd_wen, lock_err;
    logic [DW-1:0] rdata, bd_wdata, bd_rdata;
    logic [AW-1:0] bd_addr;

    iob_eth_bd_arb #(.BD_ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .tx_req_i(tx_req), .rx_req_i(rx_req), .tx_lock_i(tx_lock), .rx_lock_i(rx_lock),
        .tx_wen_i(tx_wen), .rx_wen_i(rx_wen), .tx_addr_i(tx_addr), .rx_addr_i(rx_addr),
        .tx_wdata_i(tx_wdata), .rx_wdata_i(rx_wdata),
        .tx_ack_o(tx_ack), .rx_ack_o(rx_ack), .tx_rvalid_o(tx_rvalid), .rx_rvalid_o(rx_rvalid),
        .rdata_o(rdata), .bd_en_o(bd_en), .bd_wen_o(bd_wen), .bd_addr_o(bd_addr),
        .bd_wdata_o(bd_wdata), .bd_rdata_i(bd_rdata), .lock_err_o(lock_err)
    );

    // descriptor RAM, 1-cycle read latency
    logic [DW-1:0] ram [0:255];
    logic          ram_load;
    logic [DW-1:0] seed;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= (DW'(i) * 32'h0101_0101) ^ seed;
        end else if (bd_en) begin
            if (bd_wen) ram[bd_addr] <= bd_wdata;
            else        bd_rdata <= ram[bd_addr];
        end
    end

    // reference model: owner 0=none 1=TX 2=RX, held = cycles already spent owning
    int            m_owner, m_held;
    bit            m_last_rx, m_err, m_ptx, m_prx;
    logic [DW-1:0] m_data;
    logic [DW-1:0] ref_mem [0:255];
    bit            e_tx, e_rx, e_rv;
    logic [46:0]   exp_v;
    wire  [46:0]   obs_v = {tx_ack, rx_ack, bd_en, bd_wen, bd_addr, bd_wdata, tx_rvalid, rx_rvalid, lock_err};
    int            n_checks, n_errors, cyc;

    task predict();
        bit own_req;
        e_tx = 1'b0;
        e_rx = 1'b0;
        if (!rst && cke) begin
            if (m_owner == 0) begin
                if (tx_req && rx_req) begin
`ifdef IOB_ETH_BD_ARB_RX_PRIO_EN
                    e_rx = 1'b1;
`else
                    if (m_last_rx) e_tx = 1'b1;
                    else           e_rx = 1'b1;
`endif
                end else begin
                    e_tx = tx_req;
                    e_rx = rx_req;
                end
            end else begin
                own_req = (m_owner == 1) ? tx_req : rx_req;
                if (own_req && m_held < LM) begin
                    if (m_owner == 1) e_tx = 1'b1;
                    else              e_rx = 1'b1;
                end
            end
        end
        e_rv = (m_ptx || m_prx) && !rst;
        if (e_tx)
            exp_v = {3'b101, tx_wen, tx_addr, tx_wdata, m_ptx && !rst, m_prx && !rst, m_err && !rst};
        else if (e_rx)
            exp_v = {3'b011, rx_wen, rx_addr, rx_wdata, m_ptx && !rst, m_prx && !rst, m_err && !rst};
        else
            exp_v = {4'b0000, {AW{1'b0}}, {DW{1'b0}}, m_ptx && !rst, m_prx && !rst, m_err && !rst};
    endtask

    task model_update();
        bit own_req, own_lock;
        if (rst) begin
            m_owner = 0; m_held = 0; m_last_rx = 1'b1; m_err = 1'b0; m_ptx = 1'b0; m_prx = 1'b0;
        end else if (cke) begin
            m_ptx = e_tx && !tx_wen;
            m_prx = e_rx && !rx_wen;
            if (e_tx) begin
                if (tx_wen) ref_mem[tx_addr] = tx_wdata;
                else        m_data = ref_mem[tx_addr];
            end
            if (e_rx) begin
                if (rx_wen) ref_mem[rx_addr] = rx_wdata;
                else        m_data = ref_mem[rx_addr];
            end
            if (m_owner == 0) begin
                if (e_tx) begin m_last_rx = 1'b0; if (tx_lock) begin m_owner = 1; m_held = 0; end end
                if (e_rx) begin m_last_rx = 1'b1; if (rx_lock) begin m_owner = 2; m_held = 0; end end
            end else begin
                own_req  = (m_owner == 1) ? tx_req : rx_req;
                own_lock = (m_owner == 1) ? tx_lock : rx_lock;
                if (!own_req) begin
                    m_owner = 0;
                end else if (m_held == LM) begin
                    m_err = 1'b1;
                    m_last_rx = (m_owner == 2);
                    m_owner = 0;
                end else begin
                    m_held++;
                    if (!own_lock) m_owner = 0;
                end
            end
        end
    endtask

    task eval();
        #1;
        predict();
    endtask

    task adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    task do_reset();
        rst = 1'b1; cke = 1'b1; tx_req = 1'b0; rx_req = 1'b0; tx_lock = 1'b0; rx_lock = 1'b0;
        eval();
        adv();
        rst = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1; cke = 1'b1; tx_req = 1'b1; rx_req = 1'b1; tx_lock = 1'b1; rx_lock = 1'b1;
        tx_wen = 1'b0; rx_wen = 1'b1; tx_addr = AW'($urandom); rx_addr = AW'($urandom);
        tx_wdata = $urandom; rx_wdata = $urandom;
        for (int i = 0; i < 2; i++) begin
            eval();
            n_checks++;
            if (obs_v !== 47'd0) begin
                n_errors++;
                $display("FAIL reset_outputs cyc %0d: got %h, expected all zero", cyc, obs_v);
            end
            adv();
        end
        rst = 1'b0; tx_req = 1'b0; rx_req = 1'b0;
        eval();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL post_reset cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
        end
        adv();
    endtask

    task test_single_read();
        tx_req = 1'b1; tx_lock = 1'b0; tx_wen = 1'b0; tx_addr = 8'h05; rx_req = 1'b0;
        eval();
        n_checks++;
        if (obs_v !== exp_v || tx_ack !== 1'b1 || bd_addr !== 8'h05) begin
            n_errors++;
            $display("FAIL single_read_ack: got ack=%b addr=%h vec=%h expected ack=1 addr=05 vec=%h",
                     tx_ack, bd_addr, obs_v, exp_v);
        end
        adv();
        tx_req = 1'b0;
        eval();
        n_checks++;
        if (obs_v !== exp_v || tx_rvalid !== 1'b1 || rdata !== ref_mem[5]) begin
            n_errors++;
            $display("FAIL single_read_data: got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                     tx_rvalid, rdata, ref_mem[5]);
        end
        adv();
    endtask

    task test_round_robin();
        bit a_tx, a_rx;
        do_reset();
        tx_req = 1'b1; rx_req = 1'b1; tx_lock = 1'b0; rx_lock = 1'b0;
        tx_wen = 1'b0; rx_wen = 1'b0; tx_addr = AW'($urandom); rx_addr = AW'($urandom);
        for (int i = 0; i < 8; i++) begin
            eval();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL rr_vec cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
            end
            n_checks++;
`ifdef IOB_ETH_BD_ARB_RX_PRIO_EN
            if (tx_ack !== 1'b0 || rx_ack !== 1'b1) begin
`else
            if (tx_ack !== (i % 2 == 0) || rx_ack !== (i % 2 == 1)) begin
`endif
                n_errors++;
                $display("FAIL rr_order step %0d: got tx_ack=%b rx_ack=%b", i, tx_ack, rx_ack);
            end
            if (e_rv) begin
                n_checks++;
                if (rdata !== m_data) begin
                    n_errors++;
                    $display("FAIL rr_rdata cyc %0d: got %h expected %h", cyc, rdata, m_data);
                end
            end
            a_tx = e_tx; a_rx = e_rx;
            adv();
            if (a_tx) begin tx_wen = 1'($urandom); tx_addr = AW'($urandom); tx_wdata = $urandom; end
            if (a_rx) begin rx_wen = 1'($urandom); rx_addr = AW'($urandom); rx_wdata = $urandom; end
        end
        tx_req = 1'b0; rx_req = 1'b0;
        eval();
        adv();
    endtask

    task test_lock_rmw();
        do_reset();
        tx_req = 1'b1; tx_lock = 1'b1; tx_wen = 1'b0; tx_addr = 8'h10;
        rx_req = 1'b0; rx_lock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            eval();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL rmw_vec step %0d: got %h expected %h", i, obs_v, exp_v);
            end
            n_checks++;
            if ((i == 0 && (tx_ack !== 1'b1 || rx_ack !== 1'b0)) ||
                (i == 1 && (tx_ack !== 1'b1 || rx_ack !== 1'b0 || tx_rvalid !== 1'b1 || rdata !== ref_mem[8'h10])) ||
                (i == 2 && (tx_ack !== 1'b0 || rx_ack !== 1'b1)) ||
                (i == 3 && (rx_rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF))) begin
                n_errors++;
                $display("FAIL rmw_seq step %0d: got tx_ack=%b rx_ack=%b tx_rv=%b rx_rv=%b rdata=%h",
                         i, tx_ack, rx_ack, tx_rvalid, rx_rvalid, rdata);
            end
            adv();
            case (i)
                0: begin
                    tx_lock = 1'b0; tx_wen = 1'b1; tx_wdata = 32'hDEAD_BEEF;
                    rx_req = 1'b1; rx_wen = 1'b0; rx_addr = 8'h10;
                end
                1: tx_req = 1'b0;
                2: rx_req = 1'b0;
                default: ;
            endcase
        end
        n_checks++;
        if (ram[8'h10] !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL rmw_ram: got %h expected deadbeef", ram[8'h10]);
        end
    endtask

    task test_lock_timeout();
        int tx_cnt, rx_first;
        tx_cnt = 0; rx_first = -1;
        do_reset();
        tx_req = 1'b1; tx_lock = 1'b1; tx_wen = 1'b0; tx_addr = AW'($urandom);
        rx_req = 1'b0; rx_lock = 1'b0; rx_wen = 1'b0; rx_addr = AW'($urandom);
        for (int i = 0; i < 22; i++) begin
            eval();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL timeout_vec step %0d: got %h expected %h", i, obs_v, exp_v);
            end
            if (tx_ack === 1'b1 && i < 17) tx_cnt++;
            if (rx_ack === 1'b1 && rx_first < 0) rx_first = i;
            adv();
            if (i == 0) rx_req = 1'b1;
            if (rx_first >= 0) rx_req = 1'b0;
        end
        n_checks++;
        if (tx_cnt != LM + 1 || rx_first != LM + 2 || lock_err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_seq: got tx_acks=%0d rx_first=%0d lock_err=%b expected %0d %0d 1",
                     tx_cnt, rx_first, lock_err, LM + 1, LM + 2);
        end
        tx_req = 1'b0;
        eval();
        adv();
    endtask

    task test_reset_inflight();
        do_reset();
        rx_req = 1'b1; rx_lock = 1'b1; rx_wen = 1'b0; rx_addr = AW'($urandom); tx_req = 1'b0;
        eval();
        n_checks++;
        if (rx_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL inflight_ack: got rx_ack=%b expected 1", rx_ack);
        end
        adv();
        rst = 1'b1;
        eval();
        n_checks++;
        if (rx_rvalid !== 1'b0 || obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL inflight_rvalid: got rx_rvalid=%b vec=%h expected 0 vec=%h", rx_rvalid, obs_v, exp_v);
        end
        adv();
        rst = 1'b0; rx_req = 1'b0; tx_req = 1'b1; tx_lock = 1'b0; tx_wen = 1'b1;
        eval();
        n_checks++;
        if (rx_rvalid !== 1'b0 || lock_err !== 1'b0 || tx_ack !== 1'b1 || obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL inflight_after: got rx_rv=%b lock_err=%b tx_ack=%b expected 0 0 1",
                     rx_rvalid, lock_err, tx_ack);
        end
        adv();
        tx_req = 1'b0;
    endtask

    task test_cke_hold();
        int rx_cnt, tx_first;
        rx_cnt = 0; tx_first = -1;
        do_reset();
        rx_req = 1'b1; rx_lock = 1'b1; rx_wen = 1'b1; rx_addr = AW'($urandom); rx_wdata = $urandom;
        tx_req = 1'b0; tx_lock = 1'b0; tx_wen = 1'b1; tx_addr = AW'($urandom); tx_wdata = $urandom;
        for (int i = 0; i < 22; i++) begin
            cke = !(i >= 5 && i <= 7);
            eval();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL cke_vec step %0d: got %h expected %h", i, obs_v, exp_v);
            end
            if (!cke) begin
                n_checks++;
                if ({tx_ack, rx_ack, bd_en} !== 3'b000) begin
                    n_errors++;
                    $display("FAIL cke_stall step %0d: got tx_ack=%b rx_ack=%b bd_en=%b", i, tx_ack, rx_ack, bd_en);
                end
            end
            if (rx_ack === 1'b1 && i < 20) rx_cnt++;
            if (tx_ack === 1'b1 && tx_first < 0) tx_first = i;
            adv();
            if (i == 0) tx_req = 1'b1;
            if (tx_first >= 0) tx_req = 1'b0;
        end
        n_checks++;
        if (rx_cnt != LM + 1) begin
            n_errors++;
            $display("FAIL cke_resume: got rx_acks=%0d expected %0d", rx_cnt, LM + 1);
        end
`ifndef IOB_ETH_BD_ARB_RX_PRIO_EN
        n_checks++;
        if (tx_first != LM + 5) begin
            n_errors++;
            $display("FAIL cke_release: got tx_first=%0d expected %0d", tx_first, LM + 5);
        end
`endif
        rx_req = 1'b0; tx_req = 1'b0; cke = 1'b1;
        eval();
        adv();
    endtask

    task test_random();
        bit a_tx, a_rx;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cke = ($urandom_range(0, 9) != 0);
            eval();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL random_vec cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
            end
            if (e_rv) begin
                n_checks++;
                if (rdata !== m_data) begin
                    n_errors++;
                    $display("FAIL random_rdata cyc %0d: got %h expected %h", cyc, rdata, m_data);
                end
            end
            a_tx = e_tx; a_rx = e_rx;
            adv();
            if (!tx_req || a_tx) begin
                tx_req = ($urandom_range(0, 2) != 0); tx_lock = ($urandom_range(0, 3) == 0);
                tx_wen = 1'($urandom); tx_addr = AW'($urandom); tx_wdata = $urandom;
            end
            if (!rx_req || a_rx) begin
                rx_req = ($urandom_range(0, 2) != 0); rx_lock = ($urandom_range(0, 3) == 0);
                rx_wen = 1'($urandom); rx_addr = AW'($urandom); rx_wdata = $urandom;
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        m_owner = 0; m_held = 0; m_last_rx = 1'b1; m_err = 1'b0; m_ptx = 1'b0; m_prx = 1'b0; m_data = '0;
        rst = 1'b1; cke = 1'b1; tx_req = 1'b0; rx_req = 1'b0; tx_lock = 1'b0; rx_lock = 1'b0;
        tx_wen = 1'b0; rx_wen = 1'b0; tx_addr = '0; rx_addr = '0; tx_wdata = '0; rx_wdata = '0;
        seed = $urandom;
        for (int i = 0; i < 256; i++) ref_mem[i] = (DW'(i) * 32'h0101_0101) ^ seed;
        ram_load = 1'b1;
        @(negedge clk);
        ram_load = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_rmw();
        test_lock_timeout();
        test_reset_inflight();
        test_cke_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
